// File: rtl/waterfall_ctrl_if.sv
// Bundle between the waterfall sequencer and its FFT source, display scanner and BRAM.
// slave is the sequencer side; master is the surrounding-system side.
interface waterfall_ctrl_if #(
  parameter int BIN_W  = 5,
  parameter int ROW_W  = 4,
  parameter int DATA_W = 8
);
  logic                   fft_start;
  logic                   fft_valid;
  logic [DATA_W-1:0]      fft_data;
  logic                   fft_ready;
  logic                   row_done;
  logic [ROW_W-1:0]       rows_filled;
  logic                   disp_req;
  logic [BIN_W-1:0]       disp_x;
  logic [ROW_W-1:0]       disp_y;
  logic                   disp_busy;
  logic                   disp_ack;
  logic [DATA_W-1:0]      disp_data;
  logic [ROW_W+BIN_W-1:0] bram_w_addr;
  logic [ROW_W+BIN_W-1:0] bram_r_addr;
  logic                   bram_w_en;
  logic                   bram_r_en;
  logic [DATA_W-1:0]      bram_d_in;
  logic [DATA_W-1:0]      bram_d_out;

  modport slave (
    input  fft_start, fft_valid, fft_data, disp_req, disp_x, disp_y, bram_d_out,
    output fft_ready, row_done, rows_filled, disp_busy, disp_ack, disp_data,
           bram_w_addr, bram_r_addr, bram_w_en, bram_r_en, bram_d_in
  );

  modport master (
    output fft_start, fft_valid, fft_data, disp_req, disp_x, disp_y, bram_d_out,
    input  fft_ready, row_done, rows_filled, disp_busy, disp_ack, disp_data,
           bram_w_addr, bram_r_addr, bram_w_en, bram_r_en, bram_d_in
  );
endinterface

// File: rtl/waterfall_ctrl.sv
// Waterfall history sequencer: writes FFT rows into a circular BRAM buffer and maps (bin, age) reads.
// Optional macro WATERFALL_BLANK_EN: ages not yet filled return 0 without touching the BRAM.
module waterfall_ctrl #(
  parameter int BIN_W  = 5,
  parameter int ROW_W  = 4,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             reset,
  waterfall_ctrl_if.slave bus
);
  localparam int ADDR_W = ROW_W + BIN_W;
  localparam logic [BIN_W-1:0] LAST_BIN = '1;
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin;
  logic [ROW_W-1:0]   write_row;
  logic [ROW_W-1:0]   head_row;
  logic [ROW_W-1:0]   rows_filled;
  logic               fft_ready;
  logic               row_done;
  logic               w_en;

  logic               accept;
  logic               blank_req;
  logic [ROW_W-1:0]   phys_row;
  logic               vld_p1, vld_p2;
  logic               blank_p1, blank_p2;
  logic [ADDR_W-1:0]  r_addr_p1;

  function automatic logic [ROW_W-1:0] sat_inc(input logic [ROW_W-1:0] v);
    return (v == ROW_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A start pulse inside FILL restarts the same row; COMMIT ignores it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fft_start) state_nxt = FILL;
      FILL:    if (!bus.fft_start && bus.fft_valid && bin == LAST_BIN) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fft_ready = 1'b0;
    row_done  = 1'b0;
    w_en      = 1'b0;
    case (state)
      FILL: begin
        fft_ready = 1'b1;
        w_en      = bus.fft_valid & ~bus.fft_start;
      end
      COMMIT:  row_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin         <= '0;
      write_row   <= '0;
      head_row    <= ROW_MAX;
      rows_filled <= '0;
    end else begin
      case (state)
        IDLE: if (bus.fft_start) bin <= '0;
        FILL: begin
          if (bus.fft_start)      bin <= '0;
          else if (bus.fft_valid) bin <= bin + 1'b1;
        end
        COMMIT: begin
          head_row    <= write_row;
          write_row   <= write_row + 1'b1;
          rows_filled <= sat_inc(rows_filled);
        end
        default: ;
      endcase
    end
  end

  assign bus.fft_ready   = fft_ready;
  assign bus.row_done    = row_done;
  assign bus.rows_filled = rows_filled;
  assign bus.bram_w_en   = w_en;
  assign bus.bram_w_addr = {write_row, bin};
  assign bus.bram_d_in   = w_en ? bus.fft_data : '0;

  assign phys_row = head_row - bus.disp_y;
  assign accept   = bus.disp_req & ~(vld_p1 | vld_p2);

`ifdef WATERFALL_BLANK_EN
  assign blank_req = (bus.disp_y >= rows_filled);
`else
  assign blank_req = 1'b0;
`endif

  // p1: address presented to BRAM; p2: BRAM data returned and acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      blank_p1  <= 1'b0;
      blank_p2  <= 1'b0;
      r_addr_p1 <= '0;
    end else begin
      vld_p1   <= accept;
      vld_p2   <= vld_p1;
      blank_p2 <= blank_p1;
      if (accept) begin
        blank_p1  <= blank_req;
        r_addr_p1 <= {phys_row, bus.disp_x};
      end
    end
  end

  assign bus.disp_busy   = vld_p1 | vld_p2;
  assign bus.bram_r_en   = vld_p1 & ~blank_p1;
  assign bus.bram_r_addr = r_addr_p1;
  assign bus.disp_ack    = vld_p2;
  assign bus.disp_data   = (vld_p2 & ~blank_p2) ? bus.bram_d_out : '0;
endmodule

// File: tb/tb_waterfall_ctrl.sv
// Bench for waterfall_ctrl: BRAM model, row-history reference model and read scoreboard.
module tb_waterfall_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  waterfall_ctrl_if #(.BIN_W(5), .ROW_W(4), .DATA_W(8)) bif ();
  waterfall_ctrl #(.BIN_W(5), .ROW_W(4), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bif.slave));

  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (bif.bram_w_en) mem[bif.bram_w_addr] <= bif.bram_d_in;
    if (bif.bram_r_en) bif.bram_d_out <= mem[bif.bram_r_addr];
  end

  int checks = 0;
  int errors = 0;
  int commits = 0;
  int total_commits = 0;
  int rd_seen = 0;
  logic [7:0] row_buf [32];
  logic [7:0] hist [16][32];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int filled_cnt();
    return (commits > 15) ? 15 : commits;
  endfunction

  // Scoreboard monitor: every ack pops the oldest expected read result.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.row_done) rd_seen++;
      if (bif.disp_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack actual=%0h expected=no_ack", bif.disp_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bif.disp_data !== e) begin
            errors++;
            $display("FAIL disp_data actual=%0h expected=%0h", bif.disp_data, e);
          end
        end
      end
    end
  end

  task automatic commit_model();
    for (int a = 15; a > 0; a--)
      for (int i = 0; i < 32; i++) hist[a][i] = hist[a-1][i];
    for (int i = 0; i < 32; i++) hist[0][i] = row_buf[i];
    commits++;
    total_commits++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {bif.fft_ready, bif.row_done, bif.rows_filled, bif.disp_busy,
                         bif.disp_ack, bif.bram_w_en, bif.bram_r_en}, 0);
    chk({tag, "_data"}, {bif.disp_data, bif.bram_d_in}, 0);
    chk({tag, "_addr"}, {bif.bram_w_addr, bif.bram_r_addr}, 0);
  endtask

  // Sends one row from row_buf; abort_at >= 0 restarts the row after that many samples.
  task automatic send_row(input int abort_at, input bit gaps);
    int b;
    int i;
    int ab;
    logic [7:0] d;
    ab = abort_at;
    @(negedge clk);
    bif.fft_start = 1'b1;
    bif.fft_valid = 1'b0;
    #1 chk("idle_ready", bif.fft_ready, 0);
    b = 0;
    i = 0;
    while (b < 32) begin
      @(negedge clk);
      bif.fft_start = 1'b0;
      if (ab >= 0 && i == ab) begin
        bif.fft_start = 1'b1;
        bif.fft_valid = 1'($urandom_range(0, 1));
        bif.fft_data  = 8'($urandom);
        #1 chk("abort_no_write", bif.bram_w_en, 0);
        b = 0;
        ab = -1;
        continue;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bif.fft_valid = 1'b0;
        #1 chk("gap_no_write", bif.bram_w_en, 0);
      end else begin
        d = (ab >= 0) ? (row_buf[b] ^ 8'h55) : row_buf[b];
        bif.fft_valid = 1'b1;
        bif.fft_data  = d;
        #1 chk("write", {bif.fft_ready, bif.bram_w_en, bif.bram_w_addr, bif.bram_d_in},
               {1'b1, 1'b1, 4'(commits % 16), 5'(b), d});
        b++;
        i++;
      end
    end
    @(negedge clk);
    bif.fft_valid = 1'b0;
    bif.fft_start = 1'($urandom_range(0, 1));
    #1 chk("commit_pulse", {bif.row_done, bif.fft_ready, bif.bram_w_en}, 3'b100);
    commit_model();
    @(negedge clk);
    bif.fft_start = 1'b0;
    #1 chk("after_commit", {bif.row_done, bif.fft_ready}, 2'b00);
    chk("rows_filled", bif.rows_filled, filled_cnt());
  endtask

  task automatic do_read(input int x, input int y);
    bit blank;
    int phys;
    logic [7:0] e;
    @(negedge clk);
    chk("busy_before_req", bif.disp_busy, 0);
    bif.disp_req = 1'b1;
    bif.disp_x   = 5'(x);
    bif.disp_y   = 4'(y);
    blank = 1'b0;
`ifdef WATERFALL_BLANK_EN
    blank = (y >= filled_cnt());
`endif
    phys = ((commits + 15) % 16 - y) & 15;
    e = blank ? 8'h00 : hist[y][x];
    exp_q.push_back(e);
    @(negedge clk);
    bif.disp_req = 1'($urandom_range(0, 1));
    bif.disp_x   = 5'($urandom);
    bif.disp_y   = 4'($urandom);
    #1 chk("r_en", {bif.disp_busy, bif.bram_r_en}, {1'b1, !blank});
    if (!blank) chk("r_addr", bif.bram_r_addr, {4'(phys), 5'(x)});
    @(negedge clk);
    bif.disp_req = 1'b0;
    #1 chk("busy_ack_cycle", bif.disp_busy, 1);
  endtask

  task automatic rand_read();
    int y;
`ifdef WATERFALL_BLANK_EN
    y = $urandom_range(0, 15);
`else
    y = $urandom_range(0, filled_cnt() - 1);
`endif
    do_read($urandom_range(0, 31), y);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    commits = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bif.fft_start = 1'b0;
    bif.fft_valid = 1'b0;
    bif.fft_data  = '0;
    bif.disp_req  = 1'b0;
    bif.disp_x    = '0;
    bif.disp_y    = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 32; i++) row_buf[i] = 8'(i);
    send_row(-1, 1'b0);
    do_read(5, 0);

    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < 32; i++) row_buf[i] = 8'(k);
      send_row(-1, 1'(k % 2));
    end
    chk("rows_filled_sat", bif.rows_filled, 15);
    do_read(9, 0);
    do_read(7, 1);
    do_read(20, 14);

    for (int i = 0; i < 32; i++) row_buf[i] = 8'hAA;
    send_row(10, 1'b0);
    for (int x = 0; x < 32; x++) do_read(x, 0);

    repeat (6) begin
      for (int i = 0; i < 32; i++) row_buf[i] = 8'($urandom);
      send_row(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1, 1'b1);
      repeat (4) rand_read();
    end

`ifdef WATERFALL_BLANK_EN
    reset_dut();
    for (int i = 0; i < 32; i++) row_buf[i] = 8'(i + 100);
    send_row(-1, 1'b0);
    do_read(3, 3);
    do_read(3, 0);
`endif

    @(negedge clk);
    bif.fft_start = 1'b1;
    @(negedge clk);
    bif.fft_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bif.fft_valid = 1'b1;
      bif.fft_data  = 8'($urandom);
      @(negedge clk);
    end
    bif.fft_valid = 1'b0;
    bif.disp_req  = 1'b1;
    bif.disp_x    = 5'd3;
    bif.disp_y    = 4'd0;
    @(negedge clk);
    bif.disp_req = 1'b0;
    reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    commits = 0;
    repeat (4) @(negedge clk);
    #1 chk("post_reset_idle", {bif.rows_filled, bif.disp_busy, bif.fft_ready}, 0);
    for (int i = 0; i < 32; i++) row_buf[i] = 8'($urandom);
    send_row(-1, 1'b1);
    do_read($urandom_range(0, 31), 0);
    do_read(31, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("row_done_count", rd_seen, total_commits);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
